// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and width helpers for the direct-mapped BTB and its
// saturating direction counters.
package branch_predictor_btb_pkg;

  localparam int unsigned DEF_ENTRIES = 64;
  localparam int unsigned DEF_CNT_W   = 2;
  localparam int unsigned DEF_ADDR_W  = 32;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Word-aligned PCs: the low two bits sit below the index field.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entries);
    return addr_w - idx_w(entries) - 2;
  endfunction

  function automatic int unsigned cnt_wnt(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_wt(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter next-state logic for the BTB direction predictor.
module sat_counter_next #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_next_o
);

  always_comb begin
    cnt_next_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != '1) cnt_next_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != '0) cnt_next_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry direction counters.
// Optional branch/mispredict statistics counters under `BTB_STATS_EN.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic [ADDR_W-1:0] PCF,
  output logic              PredTakenF,
  output logic [ADDR_W-1:0] PredTargetF,
  input  logic              UpdEnE,
  input  logic [ADDR_W-1:0] PCE,
  input  logic              BrTakenE,
  input  logic [ADDR_W-1:0] BrTargetE,
  input  logic              PredTakenE,
  input  logic [ADDR_W-1:0] PredTargetE,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RedirectPCE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       StatBranches,
  output logic [31:0]       StatMispredicts
`endif
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, ENTRIES);
  localparam logic [CNT_W-1:0] WNT = CNT_W'(cnt_wnt(CNT_W));
  localparam logic [CNT_W-1:0] WT  = CNT_W'(cnt_wt(CNT_W));

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CNT_W-1:0]  cnt_q   [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       unused_pcf_lsb;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[ADDR_W-1:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[ADDR_W-1:IDX_W+2];
  assign unused_pcf_lsb = PCF[1:0];

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = f_hit && cnt_q[f_idx][CNT_W-1];
  assign PredTargetF = f_hit ? tgt_q[f_idx] : '0;

  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign MispredictE = UpdEnE && ((PredTakenE != BrTakenE) ||
                       (BrTakenE && PredTakenE && (PredTargetE != BrTargetE)));
  assign RedirectPCE = BrTakenE ? BrTargetE : PCE + ADDR_W'(4);

  sat_counter_next #(.CNT_W(CNT_W)) u_sat_counter_next (
    .cnt_i      (cnt_q[e_idx]),
    .taken_i    (BrTakenE),
    .cnt_next_o (cnt_d)
  );

  // Reset takes priority: an update presented during reset is dropped.
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= WNT;
      end
    end else if (UpdEnE) begin
      if (e_hit) begin
        cnt_q[e_idx] <= cnt_d;
        if (BrTakenE) tgt_q[e_idx] <= BrTargetE;
      end else if (BrTakenE) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        tgt_q[e_idx]   <= BrTargetE;
        cnt_q[e_idx]   <= WT;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

  assign stat_br_d  = stat_br_q + (UpdEnE ? 32'd1 : 32'd0);
  assign stat_mis_d = stat_mis_q + (MispredictE ? 32'd1 : 32'd0);

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign StatBranches    = stat_br_q;
  assign StatMispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed table-driven bench for branch_predictor_btb (ENTRIES=64, CNT_W=2).
// Statistics outputs are checked when built with BTB_STATS_EN.
module tb_branch_predictor_btb;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdEnE;
  logic [31:0] PCE;
  logic        BrTakenE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
`ifdef BTB_STATS_EN
  logic [31:0] StatBranches;
  logic [31:0] StatMispredicts;
`endif

  always #5 CPU_CLK = ~CPU_CLK;

  branch_predictor_btb #(.ENTRIES(64), .CNT_W(2), .ADDR_W(32)) dut (
    .CPU_CLK     (CPU_CLK),
    .CPU_RST_N   (CPU_RST_N),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .UpdEnE      (UpdEnE),
    .PCE         (PCE),
    .BrTakenE    (BrTakenE),
    .BrTargetE   (BrTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
    .RedirectPCE (RedirectPCE)
`ifdef BTB_STATS_EN
    ,
    .StatBranches    (StatBranches),
    .StatMispredicts (StatMispredicts)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] pcf;
    logic        upd;
    logic [31:0] pce;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic        e_ptf;
    logic [31:0] e_tgtf;
    logic        e_mis;
    logic [31:0] e_redir;
  } vec_t;

  localparam int unsigned NV = 26;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic rst_n, logic [31:0] pcf, logic upd, logic [31:0] pce,
                              logic taken, logic [31:0] tgt, logic ptaken, logic [31:0] ptgt,
                              logic e_ptf, logic [31:0] e_tgtf, logic e_mis, logic [31:0] e_redir);
    vec_t v;
    v.rst_n = rst_n; v.pcf = pcf; v.upd = upd; v.pce = pce; v.taken = taken; v.tgt = tgt;
    v.ptaken = ptaken; v.ptgt = ptgt; v.e_ptf = e_ptf; v.e_tgtf = e_tgtf;
    v.e_mis = e_mis; v.e_redir = e_redir;
    return v;
  endfunction

  task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, vi, act, exp);
    end
  endtask

`ifdef BTB_STATS_EN
  logic [31:0] exp_br  = '0;
  logic [31:0] exp_mis = '0;
`endif

  initial begin
    //                rst  pcf          upd pce          tk  tgt          ptk ptgt        ePTF eTGTF        eMis eRedir
    vecs[0]  = mk(1'b0, 32'h100,      0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h100,      0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     0, 32'h0,   0, 32'h0,      1, 32'h80);
    vecs[3]  = mk(1'b1, 32'h100,      0, 32'h0,        0, 32'h0,      0, 32'h0,   1, 32'h80,     0, 32'h0);
    vecs[4]  = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     1, 32'h80,  1, 32'h80,     0, 32'h0);
    vecs[5]  = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     1, 32'h80,  1, 32'h80,     0, 32'h0);
    vecs[6]  = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     1, 32'h80,  1, 32'h80,     0, 32'h0);
    vecs[7]  = mk(1'b1, 32'h100,      1, 32'h100,      0, 32'h0,      1, 32'h80,  1, 32'h80,     1, 32'h104);
    vecs[8]  = mk(1'b1, 32'h100,      0, 32'h0,        0, 32'h0,      0, 32'h0,   1, 32'h80,     0, 32'h0);
    vecs[9]  = mk(1'b1, 32'h100,      1, 32'h100,      0, 32'h0,      1, 32'h80,  1, 32'h80,     1, 32'h104);
    vecs[10] = mk(1'b1, 32'h100,      0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h80,     0, 32'h0);
    vecs[11] = mk(1'b1, 32'h100,      1, 32'h100,      0, 32'h0,      0, 32'h0,   0, 32'h80,     0, 32'h0);
    vecs[12] = mk(1'b1, 32'h100,      1, 32'h100,      0, 32'h0,      0, 32'h0,   0, 32'h80,     0, 32'h0);
    vecs[13] = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     0, 32'h0,   0, 32'h80,     1, 32'h80);
    vecs[14] = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h80,     0, 32'h0,   0, 32'h80,     1, 32'h80);
    vecs[15] = mk(1'b1, 32'h100,      1, 32'h100,      1, 32'h90,     1, 32'h80,  1, 32'h80,     1, 32'h90);
    vecs[16] = mk(1'b1, 32'h100,      1, 32'h200,      1, 32'h300,    0, 32'h0,   1, 32'h90,     1, 32'h300);
    vecs[17] = mk(1'b1, 32'h100,      1, 32'h100,      0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[18] = mk(1'b1, 32'h200,      1, 32'h104,      0, 32'h0,      1, 32'h50,  1, 32'h300,    1, 32'h108);
    vecs[19] = mk(1'b1, 32'h104,      0, 32'h0,        0, 32'h0,      1, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[20] = mk(1'b1, 32'h203,      1, 32'hFFFFFFFC, 1, 32'h40,     0, 32'h0,   1, 32'h300,    1, 32'h40);
    vecs[21] = mk(1'b1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,      1, 32'h40,  1, 32'h40,     1, 32'h0);
    vecs[22] = mk(1'b0, 32'hFFFFFFFC, 1, 32'h400,      1, 32'h500,    0, 32'h0,   0, 32'h40,     1, 32'h500);
    vecs[23] = mk(1'b1, 32'h400,      0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[24] = mk(1'b1, 32'h200,      0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);
    vecs[25] = mk(1'b1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,      0, 32'h0,   0, 32'h0,      0, 32'h0);

    CPU_RST_N = 1'b0; PCF = '0; UpdEnE = 1'b0; PCE = '0; BrTakenE = 1'b0;
    BrTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
    @(posedge CPU_CLK);

    for (int i = 0; i < NV; i++) begin
      @(negedge CPU_CLK);
      CPU_RST_N   = vecs[i].rst_n;
      PCF         = vecs[i].pcf;
      UpdEnE      = vecs[i].upd;
      PCE         = vecs[i].pce;
      BrTakenE    = vecs[i].taken;
      BrTargetE   = vecs[i].tgt;
      PredTakenE  = vecs[i].ptaken;
      PredTargetE = vecs[i].ptgt;
      #1;
      chk("PredTakenF", i, {31'd0, PredTakenF}, {31'd0, vecs[i].e_ptf});
      chk("PredTargetF", i, PredTargetF, vecs[i].e_tgtf);
      chk("MispredictE", i, {31'd0, MispredictE}, {31'd0, vecs[i].e_mis});
      if (vecs[i].e_mis) chk("RedirectPCE", i, RedirectPCE, vecs[i].e_redir);
`ifdef BTB_STATS_EN
      chk("StatBranches", i, StatBranches, exp_br);
      chk("StatMispredicts", i, StatMispredicts, exp_mis);
      if (!vecs[i].rst_n) begin
        exp_br  = '0;
        exp_mis = '0;
      end else begin
        if (vecs[i].upd)   exp_br  = exp_br + 32'd1;
        if (vecs[i].e_mis) exp_mis = exp_mis + 32'd1;
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
